// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// Optional counter build is selected in the top with SEQ_DET_CNT_EN.
package seq_det_pkg;

    localparam int unsigned DEF_PAT_LEN = 4;
    localparam int unsigned DEF_CNT_W   = 8;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    // Bits needed to hold any value in 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Reception history shift register plus saturating fill counter.
// next_hist_o/next_fill_o expose the values that will be loaded on the coming edge.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_LEN = DEF_PAT_LEN,
    parameter int unsigned FILL_W  = clog2(PAT_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_i,
    input  logic               din_i,
    input  logic               clr_i,
    input  logic               fill_clr_i,
    output logic [PAT_LEN-1:0] next_hist_o,
    output logic [FILL_W-1:0]  next_fill_o
);

    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            hist_d = {hist_q[PAT_LEN-2:0], din_i};
            fill_d = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);
        end
    end

    // fill_clr_i is applied only at the register so next_fill_o never depends on it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_clr_i ? '0 : fill_d;
        end
    end

    assign next_hist_o = hist_d;
    assign next_fill_o = fill_d;

endmodule

// File: rtl/seq_detector_prog.sv
// Run-time programmable serial pattern detector with overlap mode and match pulse.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter logic               OVERLAP = OVL_ON,
    parameter int unsigned        CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int unsigned       FILL_W = clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] pat_q;
    logic               ovl_q;
    logic               match_q;
    logic               accept;
    logic               hit;
    logic [PAT_LEN-1:0] next_hist;
    logic [FILL_W-1:0]  next_fill;

    // A configuration load discards any bit presented in the same cycle.
    assign accept = din_valid & ~cfg_load;
    assign hit    = accept && (next_fill == FULL) && (next_hist == pat_q);

    seq_det_hist #(
        .PAT_LEN (PAT_LEN),
        .FILL_W  (FILL_W)
    ) u_hist (
        .clk         (clk),
        .rst         (rst),
        .shift_i     (accept),
        .din_i       (din),
        .clr_i       (cfg_load),
        .fill_clr_i  (hit && (ovl_q == OVL_OFF)),
        .next_hist_o (next_hist),
        .next_fill_o (next_fill)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_q   <= PATTERN;
            ovl_q   <= OVERLAP;
            match_q <= 1'b0;
        end else begin
            if (cfg_load) begin
                pat_q <= cfg_pattern;
                ovl_q <= cfg_overlap;
            end
            match_q <= hit;
        end
    end

    assign match = match_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule
